// File: rtl/alu_sequencer.sv
// Command sequencer driving an external 4-bit ALU through an accumulator.
// Optional zero flag on the response when ALUSEQ_ZFLAG_EN is defined.
module alu_sequencer #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [2:0] cmd_op_i,
    input  logic [3:0] cmd_data_i,
    output logic [3:0] alu_a_o,
    output logic [3:0] alu_b_o,
    output logic [1:0] alu_s_o,
    input  logic [3:0] alu_sum_i,
    input  logic       alu_cout_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [3:0] rsp_acc_o,
`ifdef ALUSEQ_ZFLAG_EN
    output logic       rsp_zero_o,
`endif
    output logic       rsp_carry_o
);

    localparam logic [1:0] CntInit = 2'(ALU_LAT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StRespond} state_e;

    state_e     state_q, state_d;
    logic [3:0] acc_q, acc_d;
    logic       carry_q, carry_d;
    logic [1:0] op_q, op_d;
    logic [3:0] opnd_q, opnd_d;
    logic [1:0] cnt_q, cnt_d;
    logic       cmd_accept;

    assign cmd_accept = cmd_valid_i && cmd_ready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (cmd_accept) begin
                    state_d = cmd_op_i[2] ? StRespond : StIssue;
                end
            end
            StIssue: begin
                if (cnt_q == 2'd0) begin
                    state_d = StRespond;
                end
            end
            StRespond: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready_o = (state_q == StIdle) && !rst;
        alu_a_o     = acc_q;
        alu_b_o     = (state_q == StIssue) ? opnd_q : 4'h0;
        alu_s_o     = (state_q == StIssue) ? op_q : 2'b00;
        rsp_valid_o = (state_q == StRespond);
        rsp_acc_o   = acc_q;
        rsp_carry_o = carry_q;
    end

    always_comb begin
        acc_d   = acc_q;
        carry_d = carry_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        if ((state_q == StIdle) && cmd_accept) begin
            op_d    = cmd_op_i[1:0];
            opnd_d  = cmd_data_i;
            cnt_d   = CntInit;
            carry_d = 1'b0;
            case (cmd_op_i)
                3'b100:  acc_d = cmd_data_i;
                3'b101:  acc_d = 4'h0;
                default: acc_d = acc_q;
            endcase
        end else if (state_q == StIssue) begin
            if (cnt_q == 2'd0) begin
                acc_d   = alu_sum_i;
                // Only the adder produces a carry; the incrementer has none.
                carry_d = (op_q == 2'b00) && alu_cout_i;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= 4'h0;
            carry_q <= 1'b0;
            op_q    <= 2'b00;
            opnd_q  <= 4'h0;
            cnt_q   <= 2'd0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ALUSEQ_ZFLAG_EN
    logic zero_q, zero_d;

    // Updated only when a result is produced, so it holds with the response.
    always_comb begin
        zero_d = zero_q;
        if (((state_q == StIdle) && cmd_accept) ||
            ((state_q == StIssue) && (cnt_q == 2'd0))) begin
            zero_d = (acc_d == 4'h0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign rsp_zero_o = zero_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: one instance at ALU_LAT=1, one at ALU_LAT=3,
// each wired to a behavioural 4-bit ALU.
module tb_alu_sequencer;

    logic clk;
    int   errors = 0;
    int   checks = 0;

    // Instance with ALU_LAT = 1
    logic       rst1, cv1, cr1, cout1, rv1, rr1, rc1;
    logic [2:0] op1;
    logic [3:0] cd1, a1, b1, sum1, racc1;
    logic [1:0] s1;
    // Instance with ALU_LAT = 3
    logic       rst3, cv3, cr3, cout3, rv3, rr3, rc3;
    logic [2:0] op3;
    logic [3:0] cd3, a3, b3, sum3, racc3;
    logic [1:0] s3;
`ifdef ALUSEQ_ZFLAG_EN
    logic rz1, rz3;
`endif

    alu_sequencer #(.ALU_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst1),
        .cmd_valid_i(cv1), .cmd_ready_o(cr1), .cmd_op_i(op1), .cmd_data_i(cd1),
        .alu_a_o(a1), .alu_b_o(b1), .alu_s_o(s1), .alu_sum_i(sum1), .alu_cout_i(cout1),
        .rsp_valid_o(rv1), .rsp_ready_i(rr1), .rsp_acc_o(racc1),
`ifdef ALUSEQ_ZFLAG_EN
        .rsp_zero_o(rz1),
`endif
        .rsp_carry_o(rc1)
    );

    alu_sequencer #(.ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst3),
        .cmd_valid_i(cv3), .cmd_ready_o(cr3), .cmd_op_i(op3), .cmd_data_i(cd3),
        .alu_a_o(a3), .alu_b_o(b3), .alu_s_o(s3), .alu_sum_i(sum3), .alu_cout_i(cout3),
        .rsp_valid_o(rv3), .rsp_ready_i(rr3), .rsp_acc_o(racc3),
`ifdef ALUSEQ_ZFLAG_EN
        .rsp_zero_o(rz3),
`endif
        .rsp_carry_o(rc3)
    );

    function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] s);
        case (s)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a | b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a + 4'h1};
        endcase
    endfunction

    always_comb {cout1, sum1} = alu(a1, b1, s1);
    always_comb {cout3, sum3} = alu(a3, b3, s3);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command to the ALU_LAT=1 instance with rsp_ready held high.
    task automatic do_cmd1(input string tag, input logic [2:0] op, input logic [3:0] d,
                           input logic is_alu, input logic [3:0] exp_a,
                           input logic [3:0] exp_b, input logic [1:0] exp_s,
                           input logic [3:0] exp_acc, input logic exp_c);
        cv1 = 1'b1;
        op1 = op;
        cd1 = d;
        step();
        cv1 = 1'b0;
        if (is_alu) begin
            chk({tag, ".alu_a"}, 8'(a1), 8'(exp_a));
            chk({tag, ".alu_b"}, 8'(b1), 8'(exp_b));
            chk({tag, ".alu_s"}, 8'(s1), 8'(exp_s));
            chk({tag, ".issue_rv"}, 8'(rv1), 8'h0);
            step();
        end
        chk({tag, ".rsp_valid"}, 8'(rv1), 8'h1);
        chk({tag, ".rsp_acc"}, 8'(racc1), 8'(exp_acc));
        chk({tag, ".rsp_carry"}, 8'(rc1), 8'(exp_c));
        chk({tag, ".busy_ready"}, 8'(cr1), 8'h0);
`ifdef ALUSEQ_ZFLAG_EN
        chk({tag, ".rsp_zero"}, 8'(rz1), 8'(exp_acc == 4'h0));
`endif
        step();
        chk({tag, ".done_rv"}, 8'(rv1), 8'h0);
        chk({tag, ".done_ready"}, 8'(cr1), 8'h1);
    endtask

    initial begin
        rst1 = 1'b1; cv1 = 1'b0; op1 = 3'b000; cd1 = 4'h0; rr1 = 1'b1;
        rst3 = 1'b1; cv3 = 1'b0; op3 = 3'b000; cd3 = 4'h0; rr3 = 1'b1;
        step();
        chk("rst.ready", 8'(cr1), 8'h0);
        chk("rst.rv", 8'(rv1), 8'h0);
        chk("rst.acc", 8'(racc1), 8'h0);
        chk("rst.carry", 8'(rc1), 8'h0);
        chk("rst.alu", {a1, b1}, 8'h00);
        chk("rst.alu_s", 8'(s1), 8'h0);
        rst1 = 1'b0;
        rst3 = 1'b0;
        #1;
        chk("rel.ready", 8'(cr1), 8'h1);

        //        tag       op      d     alu   a     b     s      acc   c
        do_cmd1("load5",  3'b100, 4'h5, 1'b0, 4'h0, 4'h0, 2'b00, 4'h5, 1'b0);
        do_cmd1("add6",   3'b000, 4'h6, 1'b1, 4'h5, 4'h6, 2'b00, 4'hB, 1'b0);
        do_cmd1("add7",   3'b000, 4'h7, 1'b1, 4'hB, 4'h7, 2'b00, 4'h2, 1'b1);
        do_cmd1("load5b", 3'b100, 4'h5, 1'b0, 4'h0, 4'h0, 2'b00, 4'h5, 1'b0);
        do_cmd1("or6",    3'b001, 4'h6, 1'b1, 4'h5, 4'h6, 2'b01, 4'h7, 1'b0);
        do_cmd1("and6",   3'b010, 4'h6, 1'b1, 4'h7, 4'h6, 2'b10, 4'h6, 1'b0);
        do_cmd1("loadF",  3'b100, 4'hF, 1'b0, 4'h0, 4'h0, 2'b00, 4'hF, 1'b0);
        do_cmd1("incF",   3'b011, 4'hA, 1'b1, 4'hF, 4'hA, 2'b11, 4'h0, 1'b0);
        do_cmd1("res110", 3'b110, 4'h7, 1'b0, 4'h0, 4'h0, 2'b00, 4'h0, 1'b0);
        do_cmd1("load9",  3'b100, 4'h9, 1'b0, 4'h0, 4'h0, 2'b00, 4'h9, 1'b0);
        do_cmd1("addF",   3'b000, 4'hF, 1'b1, 4'h9, 4'hF, 2'b00, 4'h8, 1'b1);
        do_cmd1("res111", 3'b111, 4'h3, 1'b0, 4'h0, 4'h0, 2'b00, 4'h8, 1'b0);
        do_cmd1("clear",  3'b101, 4'h9, 1'b0, 4'h0, 4'h0, 2'b00, 4'h0, 1'b0);

        // ALU_LAT=3: LOAD 4, then ADD 9 with rsp_ready low for 5 cycles.
        cv3 = 1'b1; op3 = 3'b100; cd3 = 4'h4;
        step();
        cv3 = 1'b0;
        chk("l3.load_acc", 8'(racc3), 8'h4);
        step();
        rr3 = 1'b0;
        cv3 = 1'b1; op3 = 3'b000; cd3 = 4'h9;
        step();
        cv3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("l3.issue_a", 8'(a3), 8'h4);
            chk("l3.issue_b", 8'(b3), 8'h9);
            chk("l3.issue_s", 8'(s3), 8'h0);
            chk("l3.issue_rv", 8'(rv3), 8'h0);
            chk("l3.issue_ready", 8'(cr3), 8'h0);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            chk("l3.hold_rv", 8'(rv3), 8'h1);
            chk("l3.hold_acc", 8'(racc3), 8'hD);
            chk("l3.hold_carry", 8'(rc3), 8'h0);
            chk("l3.hold_ready", 8'(cr3), 8'h0);
            if (i == 2) begin
                cv3 = 1'b1; op3 = 3'b100; cd3 = 4'h1;
            end
            step();
            cv3 = 1'b0;
        end
        rr3 = 1'b1;
        step();
        chk("l3.done_rv", 8'(rv3), 8'h0);
        chk("l3.done_ready", 8'(cr3), 8'h1);
        chk("l3.pulse_ignored", 8'(racc3), 8'hD);
        chk("l3.idle_b", 8'(b3), 8'h0);

        // ALU_LAT=3: reset in the second ISSUE cycle abandons the command.
        cv3 = 1'b1; op3 = 3'b000; cd3 = 4'h1;
        step();
        cv3 = 1'b0;
        step();
        chk("l3.pre_rst_b", 8'(b3), 8'h1);
        rst3 = 1'b1;
        #1;
        chk("l3.rst_acc", 8'(racc3), 8'h0);
        chk("l3.rst_alu", {a3, b3}, 8'h00);
        chk("l3.rst_s", 8'(s3), 8'h0);
        chk("l3.rst_rv", 8'(rv3), 8'h0);
        chk("l3.rst_ready", 8'(cr3), 8'h0);
        step();
        step();
        rst3 = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("l3.post_rst_rv", 8'(rv3), 8'h0);
            chk("l3.post_rst_ready", 8'(cr3), 8'h1);
            chk("l3.post_rst_acc", 8'(racc3), 8'h0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Accumulator-based command sequencer that drives the team's 4-bit ALU (add/or/and/increment, 2-bit select) from the control side. It accepts one command at a time over a valid/ready handshake, presents the accumulator and operand to the ALU, waits a configurable settle time, and captures the result back into the accumulator. It returns each result over a second valid/ready handshake, turning the combinational ALU into a command-driven datapath stage.

## Interface
- ALU_LAT, default 1: cycles the ALU inputs are held before capture; legal 1..4.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  000 ADD, 001 OR, 010 AND, 011 INC, 100 LOAD, 101 CLEAR, 110/111 reserved.
- cmd_data  in  4  operand; ignored by INC and CLEAR.
- alu_a  out  4  ALU operand A (always the accumulator).
- alu_b  out  4  ALU operand B.
- alu_s  out  2  ALU select, 00 add, 01 or, 10 and, 11 inc.
- alu_sum  in  4  ALU result.
- alu_cout  in  1  ALU adder carry-out.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_acc  out  4  accumulator value after the command.
- rsp_carry  out  1  carry produced by the command.

## Operation
- States: IDLE, ISSUE, RESPOND. cmd_ready = (state==IDLE) and not rst.
- IDLE: on cmd_valid&cmd_ready, latch op and operand.
  - op[2]==0: go to ISSUE and load the settle counter with ALU_LAT-1.
  - LOAD: acc<=cmd_data, carry<=0, go to RESPOND.
  - CLEAR: acc<=0, carry<=0, go to RESPOND.
  - Reserved: acc unchanged, carry<=0, go to RESPOND.
- ISSUE: alu_a=acc, alu_b=latched operand, alu_s=op[1:0], all stable for every ISSUE cycle. The counter decrements each cycle. On the edge where the counter is 0: acc<=alu_sum; carry<=alu_cout for ADD, else 0; go to RESPOND.
- Outside ISSUE: alu_a=acc, alu_b=0, alu_s=00.
- RESPOND: rsp_valid=1, rsp_acc=acc, rsp_carry=carry. All three are held stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE.
- Arithmetic is 4-bit modulo: ADD F+1 gives 0 with carry 1; INC F gives 0 with carry 0 (the ALU's incrementer has no carry).
- No command is accepted while a response is pending; there is no pipelining.

## Timing
- Reset, asserted asynchronously: state IDLE, acc 0, carry 0, rsp_valid 0, rsp_acc 0, rsp_carry 0, alu_a 0, alu_b 0, alu_s 00, cmd_ready 0. cmd_ready goes to 1 in the first cycle after release.
- ALU op accepted at edge k: ISSUE occupies the ALU_LAT cycles after edge k. acc is captured at edge k+ALU_LAT. rsp_valid is high from after edge k+ALU_LAT.
- LOAD/CLEAR/reserved accepted at edge k: acc updates at edge k, rsp_valid is high from after edge k.
- Response handshake at edge r: rsp_valid low and cmd_ready high after r. Minimum command spacing is ALU_LAT+2 cycles (1-cycle ops: 2).
- If rsp_ready is already high when rsp_valid rises, the response completes in one cycle.
- Reset mid-ISSUE or mid-RESPOND: the command is abandoned, no response is issued, and all outputs take their reset values immediately.

## Configuration
- ALUSEQ_ZFLAG_EN defined: adds port rsp_zero (out, 1). It is registered alongside the response, equals 1 when the new acc==0, resets to 0, and follows the same hold rules as rsp_acc.
- Not defined: the port is absent and there is no zero-detect logic; all other behaviour is identical.

## Test plan
- Reset, then LOAD 5 with rsp_ready=1 -> rsp_valid one cycle after accept; rsp_acc=5, rsp_carry=0; cmd_ready high the following cycle.
- After LOAD 5, ADD 6 (ALU_LAT=1) -> during ISSUE alu_a=5, alu_b=6, alu_s=00; rsp_acc=B, carry 0. Then ADD 7 -> rsp_acc=2, carry 1.
- acc 5: OR 6 -> rsp_acc=7, alu_s=01. Then AND 6 -> rsp_acc=6, alu_s=10, carry 0.
- LOAD F, then INC -> alu_s=11, rsp_acc=0, carry 0. Op 110 -> rsp_acc=0, carry 0.
- ALU_LAT=3, ADD with rsp_ready held low 5 cycles -> ALU inputs stable 3 cycles; rsp_valid/rsp_acc stable 5 cycles; cmd_ready 0 throughout; a cmd_valid pulse in that window is not accepted.
- ALU_LAT=3, assert rst in the second ISSUE cycle -> acc=0, all outputs at reset values that same cycle; no rsp_valid after release.
